// File: rtl/apb_bridge_arbiter.sv
// ---------------------------------------------------------------------------
// apb_bridge_arbiter
//
// Shares the single AHB slave port of the AHB-to-APB bridge among N local
// requesters. One single-beat transfer is in flight at a time:
//   IDLE -> ADDR (one NONSEQ address phase) -> DATA (wait for HREADY_OUT)
//   -> RESP (one-cycle done pulse to the winner) -> IDLE
// Winners are picked round-robin starting at ptr, which advances to the
// requester after the last winner once its transfer has completed.
//
// Parameters
//   N        number of requesters (2..8)
//   TIMEOUT  max DATA cycles with HREADY_OUT low before forcing an error
//            response; 0 disables the watchdog
//
// Ports
//   HCLK, HRESET            clock, synchronous active-high reset
//   req[N]                  request levels, held until done
//   req_addr/req_wdata      flattened per-requester 32-bit address / data
//   req_write[N]            per-requester direction (1 = write)
//   gnt[N]                  one-hot grant, ADDR through RESP
//   done[N]                 one-cycle completion pulse
//   rdata, err              read data and error status, valid with done
//   HADDR..HREADY_IN        AHB master-side signals into the bridge
//   HRDATA, HREADY_OUT,
//   HRESP                   AHB responses from the bridge
// ---------------------------------------------------------------------------
module apb_bridge_arbiter #(
    parameter int N       = 3,
    parameter int TIMEOUT = 16
) (
    input  logic            HCLK,
    input  logic            HRESET,

    input  logic [N-1:0]    req,
    input  logic [N*32-1:0] req_addr,
    input  logic [N*32-1:0] req_wdata,
    input  logic [N-1:0]    req_write,

    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic [31:0]     rdata,
    output logic            err,

    output logic [31:0]     HADDR,
    output logic [31:0]     HWDATA,
    output logic [1:0]      HTRANS,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic            HREADY_IN,

    input  logic [31:0]     HRDATA,
    input  logic            HREADY_OUT,
    input  logic [1:0]      HRESP
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value seen in the last allowed waiting DATA cycle.
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
    } xfer_t;

    state_t              state, state_nxt;
    xfer_t [N-1:0]       req_v;
    xfer_t               cur;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       win_idx;
    logic [PW-1:0]       pick_idx;
    logic                pick_vld;
    logic [N-1:0]        pick_oh;
    logic [TW-1:0]       tcnt;
    logic                data_ok;
    logic                data_to;

    // -----------------------------------------------------------------------
    // Unpack the flattened request buses into one struct per requester.
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign req_v[i] = '{addr:  req_addr[32*i +: 32],
                            wdata: req_wdata[32*i +: 32],
                            write: req_write[i]};
    end

    // (p + k) mod N without a divider; p < N and k < N so one subtract suffices.
    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return PW'(s);
    endfunction

    // -----------------------------------------------------------------------
    // Round-robin pick: first set req bit at or after ptr, wrapping.
    // -----------------------------------------------------------------------
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!pick_vld && req[rr_idx(ptr, k)]) begin
                pick_vld = 1'b1;
                pick_idx = rr_idx(ptr, k);
            end
        end
    end

    always_comb begin
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
    end

    // Completion wins over timeout when both land in the same cycle.
    assign data_ok = (state == S_DATA) && HREADY_OUT;
    assign data_to = (state == S_DATA) && !HREADY_OUT && (TIMEOUT != 0) && (tcnt == TLAST);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (pick_vld) state_nxt = S_ADDR;
            S_ADDR:  state_nxt = S_DATA;
            S_DATA:  if (data_ok || data_to) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= S_IDLE;
            ptr     <= '0;
            win_idx <= '0;
            cur     <= '0;
            gnt     <= '0;
            done    <= '0;
            rdata   <= '0;
            err     <= 1'b0;
            HTRANS  <= HT_IDLE;
            tcnt    <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        win_idx <= pick_idx;
                        cur     <= req_v[pick_idx];
                        gnt     <= pick_oh;
                        HTRANS  <= HT_NONSEQ;
                    end
                end
                S_ADDR: begin
                    HTRANS <= HT_IDLE;
                    tcnt   <= '0;
                end
                S_DATA: begin
                    if (HREADY_OUT) begin
                        // Writes leave rdata at its previous value.
                        if (!cur.write) rdata <= HRDATA;
                        err  <= |HRESP;
                        done <= gnt;
                    end else if (data_to) begin
                        err   <= 1'b1;
                        rdata <= '0;
                        done  <= gnt;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_RESP: begin
                    done <= '0;
                    gnt  <= '0;
                    ptr  <= (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign HADDR  = cur.addr;
    assign HWDATA = cur.wdata;
    assign HWRITE = cur.write;
    assign HSIZE  = 3'b010;
    assign HBURST = 3'b000;

    // The bridge only needs the real ready fed back while we wait on it.
    assign HREADY_IN = (state == S_DATA) ? HREADY_OUT : 1'b1;

endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_bridge_arbiter
//
// Directed bench for apb_bridge_arbiter (N=3, TIMEOUT=16). A transaction-
// level model tracks the one outstanding transfer by its age in cycles and
// predicts every output each cycle; a small bridge responder and requester
// behaviour live in tick(). Hand-computed literals pin grant order,
// latency, data-phase length and returned data.
// ---------------------------------------------------------------------------
module tb_apb_bridge_arbiter;

    localparam int N  = 3;
    localparam int TO = 16;

    logic            HCLK = 1'b0;
    logic            HRESET;
    logic [N-1:0]    req;
    logic [N*32-1:0] req_addr;
    logic [N*32-1:0] req_wdata;
    logic [N-1:0]    req_write;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [31:0]     rdata;
    logic            err;
    logic [31:0]     HADDR;
    logic [31:0]     HWDATA;
    logic [1:0]      HTRANS;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic            HREADY_IN;
    logic [31:0]     HRDATA;
    logic            HREADY_OUT;
    logic [1:0]      HRESP;

    always #5 HCLK = ~HCLK;

    apb_bridge_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req(req), .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
        .gnt(gnt), .done(done), .rdata(rdata), .err(err),
        .HADDR(HADDR), .HWDATA(HWDATA), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HREADY_IN(HREADY_IN),
        .HRDATA(HRDATA), .HREADY_OUT(HREADY_OUT), .HRESP(HRESP)
    );

    // ---------------- transaction-level model ----------------
    // One transfer is described by who won, what was latched, how many
    // cycles old it is, and whether it is in its response cycle.
    bit          m_busy, m_resp;
    int          m_age, m_dcnt, m_ptr, m_win;
    logic [31:0] m_rdata, m_haddr, m_hwdata;
    logic        m_err, m_hwrite;

    always @(posedge HCLK) begin
        if (HRESET) begin
            m_busy = 0; m_resp = 0; m_age = 0; m_dcnt = 0; m_ptr = 0; m_win = 0;
            m_rdata = 0; m_err = 0; m_haddr = 0; m_hwdata = 0; m_hwrite = 0;
        end else if (!m_busy) begin
            if (req != '0) begin
                bit found;
                found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req[(m_ptr + k) % N]) begin
                        found = 1;
                        m_win = (m_ptr + k) % N;
                    end
                end
                m_haddr  = req_addr[32*m_win +: 32];
                m_hwdata = req_wdata[32*m_win +: 32];
                m_hwrite = req_write[m_win];
                m_busy = 1; m_age = 1; m_resp = 0;
            end
        end else if (m_resp) begin
            m_busy = 0; m_resp = 0;
            m_ptr  = (m_win + 1) % N;
        end else if (m_age == 1) begin
            m_age = 2; m_dcnt = 0;
        end else begin
            m_dcnt++;
            if (HREADY_OUT) begin
                if (!m_hwrite) m_rdata = HRDATA;
                m_err  = (HRESP != 2'b00);
                m_resp = 1;
            end else if (TO != 0 && m_dcnt == TO) begin
                m_err = 1; m_rdata = 0; m_resp = 1;
            end
        end
    end

    // ---------------- bench state (main process only) ----------------
    int          n_tests, n_fail, cyc;
    bit          chk_en;
    int          r_cnt [N];
    int          br_wait;           // DATA wait cycles before ready; <0 = never
    logic [31:0] br_rdata;
    logic [1:0]  br_resp;
    bit          in_dp;
    int          bcnt;
    int          req_cyc;
    int          n_addr, n_data, n_done;
    logic [31:0] a_haddr, a_hwdata, d_rdata;
    logic        a_hwrite, d_err;
    logic [N-1:0] a_gnt, d_gnt, d_done;
    int          d_cyc, d_prev_cyc;
    int          ord [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp_model();
        logic [N-1:0] oh;
        oh = '0;
        oh[m_win] = 1'b1;
        chk("gnt",       32'(gnt),       m_busy ? 32'(oh) : 32'd0);
        chk("done",      32'(done),      (m_busy && m_resp) ? 32'(oh) : 32'd0);
        chk("htrans",    32'(HTRANS),    (m_busy && !m_resp && m_age == 1) ? 32'd2 : 32'd0);
        chk("hready_in", 32'(HREADY_IN), (m_busy && !m_resp && m_age == 2) ? 32'(HREADY_OUT) : 32'd1);
        chk("haddr",     HADDR,          m_haddr);
        chk("hwdata",    HWDATA,         m_hwdata);
        chk("hwrite",    32'(HWRITE),    32'(m_hwrite));
        chk("rdata",     rdata,          m_rdata);
        chk("err",       32'(err),       32'(m_err));
        chk("hsize",     32'(HSIZE),     32'd2);
        chk("hburst",    32'(HBURST),    32'd0);
    endtask

    // One clock: model compare and monitor at negedge, then requester and
    // bridge behaviour updated #1 after the rising edge.
    task automatic tick();
        logic         ap, ho, rs;
        logic [N-1:0] dn;
        bit           rdy;
        @(negedge HCLK);
        if (chk_en) cmp_model();
        if (HTRANS == 2'b10) begin
            n_addr++; a_haddr = HADDR; a_hwdata = HWDATA; a_hwrite = HWRITE; a_gnt = gnt;
        end
        if (gnt != '0 && HTRANS == 2'b00 && done == '0) n_data++;
        if (done != '0) begin
            d_prev_cyc = d_cyc; d_cyc = cyc;
            d_rdata = rdata; d_err = err; d_gnt = gnt; d_done = done;
            for (int i = 0; i < N; i++) if (done[i]) ord.push_back(i);
            n_done++;
        end
        @(posedge HCLK);
        cyc++;
        ap = (HTRANS == 2'b10); ho = HREADY_OUT; rs = HRESET; dn = done;
        #1;
        for (int i = 0; i < N; i++) begin
            if (dn[i] && r_cnt[i] > 0) r_cnt[i]--;
            req[i] = (r_cnt[i] > 0);
        end
        if (rs)                in_dp = 0;
        else if (ap)           begin in_dp = 1; bcnt = br_wait; end
        else if (in_dp && ho)  in_dp = 0;
        if (in_dp) begin
            if (br_wait < 0) rdy = 0;
            else begin
                rdy = (bcnt == 0);
                if (bcnt > 0) bcnt--;
            end
        end else rdy = 1;
        HREADY_OUT = rdy;
        HRDATA     = (in_dp && rdy) ? br_rdata : 32'hBAD0_BAD0;
        HRESP      = (in_dp && rdy) ? br_resp  : 2'b00;
    endtask

    task automatic raise(input int i, input int cnt, input logic [31:0] a,
                         input logic [31:0] wd, input logic wr);
        r_cnt[i] = cnt;
        req[i]   = 1'b1;
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = wd;
        req_write[i] = wr;
        req_cyc = cyc;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            tick();
            k++;
        end
        chk("done_count", 32'(n_done), 32'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        HRESET = 1; req = '0; req_addr = '0; req_wdata = '0; req_write = '0;
        HRDATA = '0; HREADY_OUT = 1; HRESP = '0;
        br_wait = 1; br_rdata = '0; br_resp = '0; in_dp = 0; bcnt = 0;
        n_tests = 0; n_fail = 0; cyc = 0; chk_en = 0;
        n_addr = 0; n_data = 0; n_done = 0; d_cyc = 0; d_prev_cyc = 0;
        for (int i = 0; i < N; i++) r_cnt[i] = 0;

        // ---- reset state ----
        tick();
        chk_en = 1;
        tick();
        chk("rst_gnt",       32'(gnt),       32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_htrans",    32'(HTRANS),    32'd0);
        chk("rst_hready_in", 32'(HREADY_IN), 32'd1);
        chk("rst_rdata",     rdata,          32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_haddr",     HADDR,          32'd0);
        HRESET = 0;
        tick();

        // ---- round robin, all three held: 0,1,2,0,1,2 ----
        ord.delete(); base = n_done; br_rdata = 32'h1111_0000;
        for (int i = 0; i < N; i++) raise(i, 2, 32'h8000_0100 + 32'(4*i), 32'h0, 1'b0);
        wait_done(base + 6, 200);
        for (int i = 0; i < 6; i++) chk("rr_order", (ord.size() > i) ? 32'(ord[i]) : 32'hFFFF_FFFF, 32'(i % 3));
        chk("rr_interval", 32'(d_cyc - d_prev_cyc), 32'd5);

        // ---- single read by requester 0 (ptr is back at 0) ----
        ord.delete(); base = n_done; n_data = 0; br_rdata = 32'h1234_5678;
        raise(0, 1, 32'h8000_0000, 32'h0, 1'b0);
        wait_done(base + 1, 40);
        chk("rd_rdata",   d_rdata,          32'h1234_5678);
        chk("rd_err",     32'(d_err),       32'd0);
        chk("rd_gnt_adr", 32'(a_gnt),       32'b001);
        chk("rd_gnt_rsp", 32'(d_gnt),       32'b001);
        chk("rd_done",    32'(d_done),      32'b001);
        chk("rd_latency", 32'(d_cyc - req_cyc), 32'd4);
        chk("rd_datacyc", 32'(n_data),      32'd2);

        // ---- req=101 with ptr=1: requester 2 first ----
        ord.delete(); base = n_done;
        raise(0, 1, 32'h8000_0020, 32'h0, 1'b0);
        raise(2, 1, 32'h8002_0020, 32'h0, 1'b0);
        wait_done(base + 2, 60);
        chk("rr101_first",  (ord.size() > 0) ? 32'(ord[0]) : 32'hFFFF_FFFF, 32'd2);
        chk("rr101_second", (ord.size() > 1) ? 32'(ord[1]) : 32'hFFFF_FFFF, 32'd0);

        // ---- single write by requester 1 ----
        base = n_done; n_addr = 0;
        raise(1, 1, 32'h8001_0004, 32'hDEAD_BEEF, 1'b1);
        wait_done(base + 1, 40);
        chk("wr_naddr",   32'(n_addr),      32'd1);
        chk("wr_haddr",   a_haddr,          32'h8001_0004);
        chk("wr_hwdata",  a_hwdata,         32'hDEAD_BEEF);
        chk("wr_hwrite",  32'(a_hwrite),    32'd1);
        chk("wr_done",    32'(d_done),      32'b010);
        chk("wr_err",     32'(d_err),       32'd0);
        chk("wr_latency", 32'(d_cyc - req_cyc), 32'd4);

        // ---- error response; requester drops req once granted ----
        base = n_done; br_resp = 2'b01; br_rdata = 32'h55AA_55AA;
        raise(2, 1, 32'h8002_0008, 32'h0, 1'b0);
        tick(); tick();
        r_cnt[2] = 0; req[2] = 1'b0;
        wait_done(base + 1, 40);
        chk("err_err",  32'(d_err),  32'd1);
        chk("err_done", 32'(d_done), 32'b100);
        br_resp = 2'b00;

        // ---- timeout with HREADY_OUT stuck low ----
        base = n_done; n_data = 0; br_wait = -1;
        raise(0, 1, 32'h8000_0010, 32'h0, 1'b0);
        wait_done(base + 1, 60);
        chk("to_datacyc", 32'(n_data),  32'd16);
        chk("to_err",     32'(d_err),   32'd1);
        chk("to_rdata",   d_rdata,      32'd0);
        chk("to_done",    32'(d_done),  32'b001);
        // next request proceeds normally
        base = n_done; n_data = 0; br_wait = 1; br_rdata = 32'hCAFE_0001;
        raise(1, 1, 32'h8001_0010, 32'h0, 1'b0);
        wait_done(base + 1, 40);
        chk("post_to_rdata",   d_rdata,     32'hCAFE_0001);
        chk("post_to_err",     32'(d_err),  32'd0);
        chk("post_to_datacyc", 32'(n_data), 32'd2);

        // ---- reset asserted in DATA ----
        br_wait = 5; br_rdata = 32'h7777_7777;
        raise(2, 1, 32'h8002_0030, 32'h0, 1'b0);
        tick(); tick();
        chk("mid_gnt_data", 32'(gnt), 32'b100);
        HRESET = 1;
        for (int i = 0; i < N; i++) r_cnt[i] = 0;
        req = '0;
        tick();
        chk("mid_gnt",    32'(gnt),    32'd0);
        chk("mid_done",   32'(done),   32'd0);
        chk("mid_htrans", 32'(HTRANS), 32'd0);
        HRESET = 0;
        base = n_done;
        for (int i = 0; i < 8; i++) tick();
        chk("mid_no_done", 32'(n_done), 32'(base));
        // ptr must be 0 again: with req=110 requester 1 wins first
        ord.delete(); br_wait = 1; br_rdata = 32'h0BAD_F00D;
        raise(1, 1, 32'h8001_0040, 32'h0, 1'b0);
        raise(2, 1, 32'h8002_0040, 32'h0, 1'b0);
        wait_done(base + 2, 60);
        chk("post_rst_first",  (ord.size() > 0) ? 32'(ord[0]) : 32'hFFFF_FFFF, 32'd1);
        chk("post_rst_second", (ord.size() > 1) ? 32'(ord[1]) : 32'hFFFF_FFFF, 32'd2);
        chk("post_rst_rdata",  d_rdata, 32'h0BAD_F00D);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_bridge_arbiter.md
# apb_bridge_arbiter

Round-robin arbiter and transfer sequencer that shares the single AHB slave port of the AHB-to-APB bridge among N local requesters. It takes one single-beat read or write request at a time, drives one AHB NONSEQ address phase into the bridge, and waits for the data phase to complete. It then returns read data and a status to the winning requester. It sits between the requester blocks (DMA, CPU shim, debug port) and the bridge, and it owns the bridge's HTRANS/HREADY_IN sequencing.

## Interface
- N, 3: number of requesters (2..8).
- TIMEOUT, 16: maximum number of DATA-state cycles allowed while waiting for HREADY_OUT; 0 disables the watchdog.
- HCLK  in  1  clock.
- HRESET  in  1  synchronous, active-high reset.
- req  in  N  per-requester request level; held until that requester's done.
- req_addr  in  N*32  flattened addresses; requester i occupies bits [32i+31:32i].
- req_wdata  in  N*32  flattened write data.
- req_write  in  N  1 = write, 0 = read.
- gnt  out  N  one-hot grant; high from ADDR through RESP.
- done  out  N  one-cycle completion pulse to the granted requester.
- rdata  out  32  read data; valid when any done bit is high.
- err  out  1  error status; valid with done (HRESP error or timeout).
- HADDR, HWDATA  out  32  bridge address and write data.
- HTRANS  out  2  NONSEQ (2'b10) in ADDR, IDLE (2'b00) otherwise.
- HWRITE  out  1  latched direction.
- HSIZE  out  3  constant 3'b010.
- HBURST  out  3  constant 3'b000.
- HREADY_IN  out  1  equals HREADY_OUT in DATA; 1 in every other state.
- HRDATA  in  32  bridge read data.
- HREADY_OUT  in  1  bridge ready.
- HRESP  in  2  bridge response; any nonzero value is an error.

## Operation
- The FSM has four states: IDLE, ADDR, DATA, RESP.
- **IDLE**
  - If any req bit is set, pick the winner by round-robin: the first set bit at or after ptr, wrapping modulo N.
  - Latch the winner's addr, wdata and write, and set the one-hot winner register. Next state is ADDR.
  - If no req bit is set, stay in IDLE.
- **ADDR**
  - Drive HTRANS=NONSEQ, HADDR/HWRITE from the latch, HWDATA=latched wdata, HREADY_IN=1.
  - Next state is DATA unconditionally.
- **DATA**
  - Drive HTRANS=IDLE. HADDR, HWDATA and HWRITE hold their latched values.
  - Clear the timeout counter on entry; it increments each DATA cycle with HREADY_OUT=0.
  - When HREADY_OUT=1: capture HRDATA into rdata (reads only; rdata holds its previous value on writes), set err=(HRESP!=0), and go to RESP.
  - When TIMEOUT!=0 and the counter reaches TIMEOUT while HREADY_OUT=0: set err=1, set rdata=32'h0, and go to RESP.
  - If HREADY_OUT=1 and the timeout are reached in the same cycle, HREADY_OUT wins and err follows HRESP.
- **RESP**
  - Pulse done[winner] for one cycle. rdata and err are held stable this cycle.
  - Set ptr to (winner+1) mod N. Next state is IDLE.
- Once granted, a deasserted req is ignored; the transfer still completes and done still pulses.
- req_* changes after the IDLE sampling cycle have no effect on the transfer in flight.
- gnt is registered and one-hot: gnt=winner in ADDR, DATA and RESP; gnt=0 in IDLE.
- Requests are never combined or pipelined; there is exactly one outstanding transfer.
- Reset values: state=IDLE, ptr=0, gnt=0, done=0, rdata=0, err=0, HADDR=0, HWDATA=0, HWRITE=0, HTRANS=IDLE, HREADY_IN=1.
- Reset asserted mid-transfer returns the block to IDLE on the next edge. No done pulse is issued for the aborted transfer.

## Timing
- Request sampled in IDLE at edge T.
- ADDR phase occupies cycle T+1; the bridge captures the address on the edge ending T+1.
- DATA begins at T+2 and lasts k>=1 cycles, ending on the first cycle with HREADY_OUT=1.
- With the standard bridge (one SETUP wait cycle, then ACCESS), k=2 and done pulses in cycle T+4.
- Minimum repeat interval for back-to-back requests is 4+k-1 cycles; the next IDLE sample occurs the cycle after RESP.
- With TIMEOUT=16 and HREADY_OUT stuck low, DATA lasts 16 cycles, then RESP follows with err=1.
- All outputs are registered except HREADY_IN, which is combinational from state and HREADY_OUT.

## Test plan
- **Single write:** requester 1 writes 0x8001_0004 ← 0xDEAD_BEEF. Expect HTRANS=2'b10 for exactly one cycle with that HADDR/HWDATA and HWRITE=1, then done[1] pulse with err=0, 4 cycles after sampling.
- **Single read:** requester 0 reads 0x8000_0000 and the bridge model returns HRDATA=0x1234_5678 on the HREADY_OUT=1 cycle. Expect rdata=0x1234_5678 with done[0] and gnt=3'b001 from ADDR through RESP.
- **Round-robin fairness:** req=3'b111 held continuously. Expect grant order 0,1,2,0,1,2. With req=3'b101 and ptr=1, expect requester 2 to win first.
- **Error response:** the bridge returns HRESP=2'b01 on completion. Expect done with err=1.
- **Timeout:** HREADY_OUT held at 0. Expect exactly 16 DATA cycles, then done with err=1 and rdata=0, after which the next request proceeds normally.
- **Reset mid-transfer:** assert HRESET in DATA. Expect IDLE on the next edge, gnt=0, no done pulse, ptr=0, and the first request after reset to complete normally.
